// File: rtl/alu_exec_unit.sv
// ALU execution unit: one operation per valid/ready handshake, registered result plus Zero/Illegal flags.
// Define MUL_EN to build the iterative shift-add multiply (code 110); otherwise 110 is an illegal code.
//   state | meaning
//   IDLE  | no result held, ready for a request
//   BUSY  | multiply in progress (MUL_EN only)
//   DONE  | result held on outputs until out_ready
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

`ifdef MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int         CW     = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } state_t;
`endif

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_res_d;
    logic             alu_ill_d;
    logic             accept;

`ifdef MUL_EN
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_d;
    logic             is_mul;

    // Multiplicand shifts left, multiplier shifts right; one partial product per cycle.
    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign is_mul = (ALUControl == OP_MUL);
`endif

    always_comb begin
        alu_res_d = '0;
        alu_ill_d = 1'b0;
        case (ALUControl)
            OP_ADD:  alu_res_d = SrcA + SrcB;
            OP_SUB:  alu_res_d = SrcA - SrcB;
            OP_AND:  alu_res_d = SrcA & SrcB;
            OP_OR:   alu_res_d = SrcA | SrcB;
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef MUL_EN
            OP_MUL:  alu_res_d = '0;
`endif
            default: alu_ill_d = 1'b1;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end else if (state_q == DONE) begin
                in_ready = out_ready;
            end
        end
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef MUL_EN
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
`endif
        end else begin
            case (state_q)
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef MUL_EN
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_d;
                        zero_q      <= (acc_d == '0);
                        illegal_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: ;
            endcase

            // A new request overrides the DONE->IDLE drain in the same cycle.
            if (accept) begin
`ifdef MUL_EN
                if (is_mul) begin
                    state_q     <= BUSY;
                    out_valid_q <= 1'b0;
                    cnt_q       <= CW'(WIDTH - 1);
                    acc_q       <= '0;
                    mcand_q     <= SrcA;
                    mplier_q    <= SrcB;
                end else
`endif
                begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    result_q    <= alu_res_d;
                    zero_q      <= (alu_res_d == '0);
                    illegal_q   <= alu_ill_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   ALUControl = 3'b000;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         Illegal;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    // Expected {Illegal, Zero, ALUResult} straight from the operation definitions.
    function automatic logic [W+1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         il;
        r  = '0;
        il = 1'b0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
`ifdef MUL_EN
            3'd6: r = a * b;
`endif
            default: il = 1'b1;
        endcase
        return {il, (r == '0), r};
    endfunction

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy);
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        out_ready  = rdy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if ({out_valid, Zero, Illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {out_valid, Zero, Illegal}); end
        checks++; if (ALUResult !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", ALUResult); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        send(3'b000, 32'd5, 32'd7, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        checks++; if ({Illegal, Zero, ALUResult} !== {1'b0, 1'b0, 32'd12}) begin errors++; $display("FAIL add_result: got %b %b %h want 0 0 0000000c", Illegal, Zero, ALUResult); end
    endtask

    task automatic test_sub();
        send(3'b001, 32'd3, 32'd3, 1'b1);
        checks++; if ({Zero, ALUResult} !== {1'b1, 32'd0}) begin errors++; $display("FAIL sub_zero: got %b %h want 1 00000000", Zero, ALUResult); end
        send(3'b001, 32'd0, 32'd1, 1'b1);
        checks++; if ({Zero, ALUResult} !== {1'b0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sub_wrap: got %b %h want 0 ffffffff", Zero, ALUResult); end
    endtask

    task automatic test_slt();
        send(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1);
        checks++; if (ALUResult !== 32'd1) begin errors++; $display("FAIL slt_neg: got %h want 1", ALUResult); end
        send(3'b101, 32'd1, 32'hFFFF_FFFF, 1'b1);
        checks++; if ({Zero, ALUResult} !== {1'b1, 32'd0}) begin errors++; $display("FAIL slt_pos: got %b %h want 1 0", Zero, ALUResult); end
    endtask

    task automatic test_backpressure();
        idle_cycle();
        send(3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            ALUControl = 3'b000;
            SrcA       = 32'd100 + i;
            SrcB       = 32'd1;
            out_ready  = 1'b0;
            #1;
            checks++; if ({out_valid, in_ready, ALUResult} !== {1'b1, 1'b0, 32'h0000_00F0}) begin errors++; $display("FAIL bp_hold%0d: got v=%b r=%b %h want 1 0 000000f0", i, out_valid, in_ready, ALUResult); end
        end
        @(negedge clk);
        ALUControl = 3'b011;
        SrcA       = 32'h1;
        SrcB       = 32'h2;
        out_ready  = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_passthru: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if ({out_valid, ALUResult} !== {1'b1, 32'h3}) begin errors++; $display("FAIL bp_next: got %b %h want 1 00000003", out_valid, ALUResult); end
    endtask

    task automatic test_illegal();
        send(3'b111, 32'd9, 32'd9, 1'b1);
        checks++; if ({out_valid, Illegal, Zero, ALUResult} !== {3'b111, 32'd0}) begin errors++; $display("FAIL illegal_111: got %b%b%b %h want 111 0", out_valid, Illegal, Zero, ALUResult); end
        send(3'b100, 32'd4, 32'd1, 1'b1);
        checks++; if ({Illegal, Zero, ALUResult} !== {2'b11, 32'd0}) begin errors++; $display("FAIL illegal_100: got %b%b %h want 11 0", Illegal, Zero, ALUResult); end
        send(3'b000, 32'd1, 32'd1, 1'b1);
        checks++; if ({Illegal, ALUResult} !== {1'b0, 32'd2}) begin errors++; $display("FAIL illegal_clear: got %b %h want 0 2", Illegal, ALUResult); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[5] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd5};
        logic [W-1:0] as[5]  = '{32'h7FFF_FFFF, 32'hA0, 32'd10, 32'hFF00, 32'h8000_0000};
        logic [W-1:0] bs[5]  = '{32'd1, 32'h0B, 32'd20, 32'h0FF0, 32'h7FFF_FFFF};
        logic [W+1:0] exp;
        for (int i = 0; i < 5; i++) begin
            send(ops[i], as[i], bs[i], 1'b1);
            exp = ref_model(ops[i], as[i], bs[i]);
            checks++; if ({out_valid, Illegal, Zero, ALUResult} !== {1'b1, exp}) begin errors++; $display("FAIL b2b_%0d: got v=%b %b%b %h want 1 %b%b %h", i, out_valid, Illegal, Zero, ALUResult, exp[W+1], exp[W], exp[W-1:0]); end
        end
    endtask

`ifdef MUL_EN
    task automatic test_mul();
        idle_cycle();
        send(3'b110, 32'd1234, 32'd5678, 1'b1);
        for (int i = 0; i < W; i++) begin
            checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy%0d: got r=%b v=%b want 0 0", i, in_ready, out_valid); end
            @(posedge clk);
            #1;
        end
        checks++; if ({out_valid, Illegal, Zero, ALUResult} !== {3'b100, 32'd7006652}) begin errors++; $display("FAIL mul_result: got %b%b%b %0d want 100 7006652", out_valid, Illegal, Zero, ALUResult); end
        idle_cycle();
        send(3'b110, 32'hFFFF_FFFF, 32'd3, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({in_ready, out_valid, ALUResult} !== {2'b00, 32'd0}) begin errors++; $display("FAIL mul_abort: got r=%b v=%b %h want 0 0 0", in_ready, out_valid, ALUResult); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL mul_abort_idle: got r=%b v=%b want 1 0", in_ready, out_valid); end
        repeat (W + 2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_abort_lost: got %b want 0", out_valid); end
    endtask
`else
    task automatic test_mul();
        idle_cycle();
        send(3'b110, 32'd1234, 32'd5678, 1'b1);
        checks++; if ({out_valid, Illegal, Zero, ALUResult} !== {3'b111, 32'd0}) begin errors++; $display("FAIL mul_illegal: got %b%b%b %h want 111 0", out_valid, Illegal, Zero, ALUResult); end
    endtask
`endif

    task automatic test_random();
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        logic [2:0]   op;
        idle_cycle();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6 && $urandom_range(0, 3) != 0) op = 3'd0;
            in_valid   = 1'($urandom_range(0, 1));
            ALUControl = op;
            SrcA       = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
            SrcB       = ($urandom_range(0, 3) == 0) ? SrcA : W'($urandom());
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got result %h with nothing outstanding", ALUResult);
                end else begin
                    exp = q.pop_front();
                    if ({Illegal, Zero, ALUResult} !== exp) begin errors++; $display("FAIL rand_cycle%0d: got %b%b %h want %b%b %h", c, Illegal, Zero, ALUResult, exp[W+1], exp[W], exp[W-1:0]); end
                end
            end
            if (in_valid && in_ready) q.push_back(ref_model(ALUControl, SrcA, SrcB));
        end
        for (int c = 0; c < 100 && q.size() != 0; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                exp = q.pop_front();
                checks++; if ({Illegal, Zero, ALUResult} !== exp) begin errors++; $display("FAIL rand_drain: got %b%b %h want %b%b %h", Illegal, Zero, ALUResult, exp[W+1], exp[W], exp[W-1:0]); end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_timeout: got %0d results outstanding want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
